// File: rtl/spi_flash_responder.sv
// SPI-mode-0 serial flash responder supporting READ (0x03) and JEDEC ID (0x9F).
// The SPI pins are oversampled by the system clock through 2-flop synchronizers.
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        CLK,
   input  logic        CS_N,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISO_OE,
   output logic        mem_rd,
   output logic [23:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        cmd_err
);

   localparam logic [7:0] OpRead = 8'h03;
   localparam logic [7:0] OpJedec = 8'h9F;

   typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StId, StIgnore} state_e;

   // sck_q[2] is the previous synchronized SCK, used for edge detection
   logic [2:0] sck_q;
   logic [1:0] csn_q;
   logic [1:0] mosi_q;
   logic       sck_rise, sck_fall, cs_hi, mosi_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q  <= 3'b000;
         csn_q  <= 2'b11;
         mosi_q <= 2'b00;
      end else begin
         sck_q  <= {sck_q[1:0], CLK};
         csn_q  <= {csn_q[0], CS_N};
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign cs_hi    = csn_q[1];
   assign mosi_s   = mosi_q[1];

   // After reset, only accept a command once CS_N has really been seen high
   logic [1:0] settle_q;
   logic       armed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_q <= 2'd0;
         armed_q  <= 1'b0;
      end else begin
         if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
         if (settle_q == 2'd2 && cs_hi) armed_q <= 1'b1;
      end
   end

   state_e      state_q;
   logic [2:0]  bit_cnt_q;
   logic [1:0]  byte_idx_q;
   logic [6:0]  cmd_q;
   logic [22:0] addr_q;
   logic [23:0] next_addr_q;
   logic [7:0]  tx_q;
   logic [7:0]  buf_q;
   logic        rd_dly_q;
   logic        miso_q, miso_oe_q, mem_rd_q, cmd_err_q;
   logic [23:0] mem_addr_q;
   logic [7:0]  opcode;
   logic [23:0] addr_full;
   logic [7:0]  id_byte;

   assign opcode    = {cmd_q, mosi_s};
   assign addr_full = {addr_q, mosi_s};

   always_comb begin
      id_byte = JEDEC_ID[7:0];
      case (byte_idx_q)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         default: id_byte = JEDEC_ID[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         bit_cnt_q   <= 3'd0;
         byte_idx_q  <= 2'd0;
         cmd_q       <= 7'd0;
         addr_q      <= 23'd0;
         next_addr_q <= 24'd0;
         tx_q        <= 8'd0;
         buf_q       <= 8'd0;
         rd_dly_q    <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= 24'd0;
         cmd_err_q   <= 1'b0;
      end else begin
         mem_rd_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         rd_dly_q  <= mem_rd_q;
         if (cs_hi) begin
            // Deselect wins over any edge seen in the same cycle
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            rd_dly_q   <= 1'b0;
         end else begin
            if (rd_dly_q) buf_q <= mem_rdata;
            case (state_q)
               StIdle: begin
                  if (armed_q) begin
                     state_q    <= StCmd;
                     bit_cnt_q  <= 3'd0;
                     byte_idx_q <= 2'd0;
                  end
               end
               StCmd: begin
                  if (sck_rise) begin
                     cmd_q     <= opcode[6:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        case (opcode)
                           OpRead:  state_q <= StAddr;
                           OpJedec: state_q <= StId;
                           default: begin
                              state_q   <= StIgnore;
                              cmd_err_q <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               StAddr: begin
                  if (sck_rise) begin
                     addr_q    <= addr_full[22:0];
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd7) begin
                        if (byte_idx_q == 2'd2) begin
                           byte_idx_q  <= 2'd0;
                           mem_rd_q    <= 1'b1;
                           mem_addr_q  <= addr_full;
                           next_addr_q <= addr_full + 24'd1;
                           state_q     <= StData;
                        end else begin
                           byte_idx_q <= byte_idx_q + 2'd1;
                        end
                     end
                  end
               end
               StData: begin
                  if (sck_fall) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd0) begin
                        // Load the prefetched byte and fetch the next one
                        tx_q        <= {buf_q[6:0], 1'b0};
                        miso_q      <= buf_q[7];
                        miso_oe_q   <= 1'b1;
                        mem_rd_q    <= 1'b1;
                        mem_addr_q  <= next_addr_q;
                        next_addr_q <= next_addr_q + 24'd1;
                     end else begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                     end
                  end
               end
               StId: begin
                  if (sck_fall) begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == 3'd0) begin
                        tx_q       <= {id_byte[6:0], 1'b0};
                        miso_q     <= id_byte[7];
                        miso_oe_q  <= 1'b1;
                        byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
                     end else begin
                        miso_q <= tx_q[7];
                        tx_q   <= {tx_q[6:0], 1'b0};
                     end
                  end
               end
               StIgnore: begin
                  miso_q    <= 1'b0;
                  miso_oe_q <= 1'b0;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign MISO     = miso_q & miso_oe_q;
   assign MISO_OE  = miso_oe_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign busy     = (state_q != StIdle);
   assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a behavioural SPI master plus a
// registered memory model with fixed contents.
module tb_spi_flash_responder;

   localparam int H = 50;  // SCK half period in ns (clk period is 10 ns)

   logic        clk = 1'b0;
   logic        rst;
   logic        CLK, CS_N, MOSI;
   logic        MISO, MISO_OE, mem_rd, busy, cmd_err;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata = 8'h00;

   int total = 0;
   int bad = 0;
   logic [23:0] rd_log[$];
   int err_n = 0;
   int oe_n = 0;
   int miso_bad = 0;

   spi_flash_responder #(.JEDEC_ID(24'hEF4016)) dut (
      .clk      (clk),
      .rst      (rst),
      .CLK      (CLK),
      .CS_N     (CS_N),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .MISO_OE  (MISO_OE),
      .mem_rd   (mem_rd),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_val(input logic [23:0] a);
      case (a)
         24'h000010: return 8'hA5;
         24'h000011: return 8'h3C;
         24'h000020: return 8'h5A;
         24'h000021: return 8'h77;
         24'hFFFFFF: return 8'hC3;
         24'h000000: return 8'h96;
         default:    return a[7:0] ^ 8'h33;
      endcase
   endfunction

   always @(posedge clk) if (mem_rd) mem_rdata <= mem_val(mem_addr);

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd) rd_log.push_back(mem_addr);
         if (cmd_err) err_n++;
         if (MISO_OE) oe_n++;
         if (!MISO_OE && MISO) miso_bad++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      rd_log.delete();
      err_n = 0;
      oe_n  = 0;
   endtask

   task automatic chk_log(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                          input logic [23:0] e2);
      logic [23:0] e[3];
      e[0] = e0;
      e[1] = e1;
      e[2] = e2;
      chk({tag, " rd count"}, rd_log.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < rd_log.size()) chk($sformatf("%s rd addr %0d", tag, i), rd_log[i], e[i]);
   endtask

   task automatic spi_begin();
      CLK  = 1'b0;
      CS_N = 1'b0;
      #(H);
   endtask

   // Mode 0: MOSI changes with the falling edge, MISO sampled at the rising edge
   task automatic spi_bit(input logic b, output logic r);
      CLK  = 1'b0;
      MOSI = b;
      #(H);
      r   = MISO;
      CLK = 1'b1;
      #(H);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], r);
         rx[i] = r;
      end
   endtask

   // Final falling edge coincides with deselect, so no further byte is loaded
   task automatic spi_end();
      CLK  = 1'b0;
      CS_N = 1'b1;
      MOSI = 1'b0;
      #(6 * H);
   endtask

   task automatic do_read(input logic [23:0] a, output logic [7:0] d0, output logic [7:0] d1);
      logic [7:0] rx;
      spi_begin();
      spi_byte(8'h03, rx);
      spi_byte(a[23:16], rx);
      spi_byte(a[15:8], rx);
      spi_byte(a[7:0], rx);
      spi_byte(8'h00, d0);
      spi_byte(8'h00, d1);
      spi_end();
   endtask

   initial begin
      logic [7:0] d0, d1, rx;
      logic       r;
      rst  = 1'b1;
      CS_N = 1'b1;
      CLK  = 1'b0;
      MOSI = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset MISO", MISO, 0);
      chk("reset MISO_OE", MISO_OE, 0);
      chk("reset mem_rd", mem_rd, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset busy", busy, 0);
      chk("reset cmd_err", cmd_err, 0);
      repeat (10) @(negedge clk);

      // READ at 0x10
      clear_mon();
      spi_begin();
      spi_byte(8'h03, rx);
      chk("read busy", busy, 1);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      spi_byte(8'h00, d0);
      spi_byte(8'h00, d1);
      spi_end();
      chk("read byte0", d0, 8'hA5);
      chk("read byte1", d1, 8'h3C);
      chk_log("read", 24'h000010, 24'h000011, 24'h000012);
      chk("idle busy", busy, 0);

      // Address wrap
      clear_mon();
      do_read(24'hFFFFFF, d0, d1);
      chk("wrap byte0", d0, 8'hC3);
      chk("wrap byte1", d1, 8'h96);
      chk_log("wrap", 24'hFFFFFF, 24'h000000, 24'h000001);

      // JEDEC ID, four bytes
      clear_mon();
      spi_begin();
      spi_byte(8'h9F, rx);
      spi_byte(8'h00, rx);
      chk("id byte0", rx, 8'hEF);
      spi_byte(8'h00, rx);
      chk("id byte1", rx, 8'h40);
      spi_byte(8'h00, rx);
      chk("id byte2", rx, 8'h16);
      spi_byte(8'h00, rx);
      chk("id byte3", rx, 8'hEF);
      spi_end();
      chk("id no mem_rd", rd_log.size(), 0);
      chk("id oe seen", oe_n > 0, 1);

      // Unsupported opcode
      clear_mon();
      spi_begin();
      spi_byte(8'h05, rx);
      spi_byte(8'hFF, d0);
      spi_byte(8'h00, d1);
      spi_end();
      chk("bad cmd_err pulses", err_n, 1);
      chk("bad oe cycles", oe_n, 0);
      chk("bad miso", {d0, d1}, 16'h0000);
      chk("bad no mem_rd", rd_log.size(), 0);
      do_read(24'h000010, d0, d1);
      chk("after bad byte0", d0, 8'hA5);

      // Abort after 12 address bits, then a full READ at 0x20
      clear_mon();
      spi_begin();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      for (int i = 0; i < 4; i++) spi_bit(i[0], r);
      spi_end();
      chk("abort no mem_rd", rd_log.size(), 0);
      clear_mon();
      do_read(24'h000020, d0, d1);
      chk("abort read byte0", d0, 8'h5A);
      chk("abort read byte1", d1, 8'h77);
      chk_log("abort read", 24'h000020, 24'h000021, 24'h000022);

      // Reset pulse in the middle of data byte 1
      clear_mon();
      spi_begin();
      spi_byte(8'h03, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h00, rx);
      spi_byte(8'h10, rx);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst MISO_OE", MISO_OE, 0);
      chk("rst MISO", MISO, 0);
      chk("rst busy", busy, 0);
      chk("rst mem_rd", mem_rd, 0);
      chk("rst mem_addr", mem_addr, 0);
      clear_mon();
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      spi_byte(8'h03, rx);
      chk("rst still idle", busy, 0);
      spi_end();
      chk("rst no mem_rd", rd_log.size(), 0);
      chk("rst no oe", oe_n, 0);
      do_read(24'h000011, d0, d1);
      chk("post rst byte0", d0, 8'h3C);
      chk("post rst byte1", d1, 8'h21);

      chk("miso low without oe", miso_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
